// File: rtl/uart_pkg.sv
// Shared constants for the UART blocks: parity modes, receiver state encoding
// and a width helper usable in parameter context.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] PARITY     = 3'd3;
    localparam logic [2:0] STOP       = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;
    localparam logic [2:0] BREAK_WAIT = 3'd6;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is chosen by the instantiator so an idle line does not look active.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments let both flops sample on the same edge,
    // giving a true two-stage chain instead of a single collapsed register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: mid-bit sampling, false-start rejection, parity
// and framing checks, single-cycle valid strobe and break handling.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic                 w_rx_s;
    logic                 w_bit_tick;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_par_bad;
    logic                 r_stop_bad;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    assign w_bit_tick = (r_cnt == BIT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == DATA || r_state == PARITY || r_state == STOP) begin
                r_cnt <= w_bit_tick ? '0 : r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state    <= DATA;
                            r_idx      <= '0;
                            r_par_acc  <= 1'b0;
                            r_par_bad  <= 1'b0;
                            r_stop_bad <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= r_par_acc ^ w_rx_s;
                        if (r_idx == DATA_LAST) begin
                            r_idx   <= '0;
                            r_state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_par_bad <= (PARITY_MODE == PAR_ODD) ? ~(r_par_acc ^ w_rx_s)
                                                              :  (r_par_acc ^ w_rx_s);
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        // Results are loaded on the last stop sample so they are
                        // already visible, with o_valid, during the DONE cycle.
                        if (r_idx == STOP_LAST) begin
                            r_state      <= DONE;
                            r_data       <= r_shift;
                            r_valid      <= 1'b1;
                            r_parity_err <= r_par_bad;
                            r_frame_err  <= r_stop_bad | ~w_rx_s;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_stop_bad <= r_stop_bad | ~w_rx_s;
                        end
                    end
                end
                DONE: begin
                    r_state <= r_frame_err ? BREAK_WAIT : IDLE;
                end
                BREAK_WAIT: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != IDLE);

endmodule
